// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. a long-latency result unit,
// with anti-starvation bubble request and an outstanding-destination scoreboard.
module wb_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteW,
    input  logic [4:0]  RD_W,
    input  logic [31:0] ResultW,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issue_rd,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wd,
    output logic        stall_req,
    output logic [31:0] busy,
    output logic        err
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX  = CW'(MAX_WAIT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] r_wait_cnt;
    logic          r_stall_req;
    logic [31:0]   r_busy;
    logic          r_err;
    logic          r_rf_we;
    logic [4:0]    r_rf_rd;
    logic [31:0]   r_rf_wd;

    logic          w_pipe_req;
    logic          w_violation;
    logic          w_xfer;
    logic          w_lu_wr;
    logic          w_refused;
    logic          w_issue_set;
    logic          w_issue_conflict;
    logic          w_orphan;
    logic [31:0]   w_busy_nxt;
    logic [CW-1:0] w_wait_nxt;

    assign w_pipe_req  = RegWriteW && (RD_W != '0);
    assign w_violation = w_pipe_req && r_stall_req;
    // A contract violation during the bubble keeps the pipeline write and refuses the unit.
    assign lu_ready    = (!w_pipe_req || r_stall_req) && !w_violation;
    assign w_xfer      = lu_valid && lu_ready;
    assign w_lu_wr     = w_xfer && (lu_rd != '0);
    assign w_refused   = lu_valid && !lu_ready;
    assign w_issue_set = lu_issue && (lu_issue_rd != '0);

    // Re-issuing to a register whose result retires this same cycle is legal.
    assign w_issue_conflict = w_issue_set && r_busy[lu_issue_rd]
                              && !(w_lu_wr && (lu_rd == lu_issue_rd));
    assign w_orphan         = w_lu_wr && !r_busy[lu_rd];

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_lu_wr)
            w_busy_nxt[lu_rd] = 1'b0;
        if (w_issue_set)
            w_busy_nxt[lu_issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (!lu_valid || w_xfer)
            w_wait_nxt = '0;
        else if (r_wait_cnt != WAIT_MAX)
            w_wait_nxt = r_wait_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt  <= '0;
            r_stall_req <= 1'b0;
            r_busy      <= '0;
            r_err       <= 1'b0;
            r_rf_we     <= 1'b0;
            r_rf_rd     <= '0;
            r_rf_wd     <= '0;
        end else begin
            r_wait_cnt  <= w_wait_nxt;
            r_stall_req <= w_refused && (r_wait_cnt == WAIT_LAST) && !r_stall_req;
            r_busy      <= w_busy_nxt;
            if (w_violation || w_issue_conflict || w_orphan)
                r_err <= 1'b1;
            r_rf_we <= w_pipe_req || w_lu_wr;
            if (w_pipe_req) begin
                r_rf_rd <= RD_W;
                r_rf_wd <= ResultW;
            end else if (w_lu_wr) begin
                r_rf_rd <= lu_rd;
                r_rf_wd <= lu_data;
            end
        end
    end

    assign stall_req = r_stall_req;
    assign busy      = r_busy;
    assign err       = r_err;
    assign rf_we     = r_rf_we;
    assign rf_rd     = r_rf_rd;
    assign rf_wd     = r_rf_wd;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected register-file writes are queued by the
// stimulus and checked by an independent monitor; control outputs are checked inline.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  RD_W;
    logic [31:0] ResultW;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        lu_issue;
    logic [4:0]  lu_issue_rd;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        stall_req;
    logic [31:0] busy;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    wb_port_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .RegWriteW(RegWriteW), .RD_W(RD_W), .ResultW(ResultW),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
        .stall_req(stall_req), .busy(busy), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back({rd, d});
    endtask

    // Monitor: every register-file write must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [36:0] e;
        if (rst === 1'b1 && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write_rd", {27'd0, rf_rd}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_rd", {27'd0, rf_rd}, {27'd0, e[36:32]});
                chk("write_wd", rf_wd, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        RegWriteW = 1'b0; RD_W = '0; ResultW = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
        lu_issue = 1'b0; lu_issue_rd = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("idle_rf_we", {31'd0, rf_we}, 32'd0);
        chk("idle_rf_rd", {27'd0, rf_rd}, 32'd0);
        chk("idle_rf_wd", rf_wd, 32'd0);
        chk("idle_err", {31'd0, err}, 32'd0);
        chk("idle_lu_ready", {31'd0, lu_ready}, 32'd1);

        // Plain pipeline write
        next_cycle();
        RegWriteW = 1'b1; RD_W = 5'd5; ResultW = 32'hDEADBEEF;
        push(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("pipe_lu_ready", {31'd0, lu_ready}, 32'd0);
        next_cycle();
        RegWriteW = 1'b0;
        @(negedge clk);
        chk("after_pipe_lu_ready", {31'd0, lu_ready}, 32'd1);

        // Starvation bubble with pipeline continuously writing x3
        next_cycle();
        lu_issue = 1'b1; lu_issue_rd = 5'd7;
        @(negedge clk);
        chk("busy7_before", {31'd0, busy[7]}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            lu_issue = 1'b0;
            RegWriteW = 1'b1; RD_W = 5'd3; ResultW = 32'h3000_0000 + 32'(i);
            lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h1234;
            push(5'd3, 32'h3000_0000 + 32'(i));
            @(negedge clk);
            chk("wait_lu_ready", {31'd0, lu_ready}, 32'd0);
            chk("wait_stall", {31'd0, stall_req}, 32'd0);
            chk("wait_busy7", {31'd0, busy[7]}, 32'd1);
        end
        next_cycle();
        RegWriteW = 1'b0;
        push(5'd7, 32'h1234);
        @(negedge clk);
        chk("bubble_stall", {31'd0, stall_req}, 32'd1);
        chk("bubble_lu_ready", {31'd0, lu_ready}, 32'd1);
        chk("bubble_busy7", {31'd0, busy[7]}, 32'd1);
        next_cycle();
        lu_valid = 1'b0;
        RegWriteW = 1'b1; RD_W = 5'd3; ResultW = 32'h3000_0004;
        push(5'd3, 32'h3000_0004);
        @(negedge clk);
        chk("post_bubble_stall", {31'd0, stall_req}, 32'd0);
        chk("post_bubble_busy7", {31'd0, busy[7]}, 32'd0);
        chk("post_bubble_err", {31'd0, err}, 32'd0);
        next_cycle();
        RegWriteW = 1'b0;

        // Long-latency result to x0: handshake, no write
        next_cycle();
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h55;
        @(negedge clk);
        chk("x0_lu_ready", {31'd0, lu_ready}, 32'd1);
        next_cycle();
        lu_valid = 1'b0;
        @(negedge clk);
        chk("x0_rf_we", {31'd0, rf_we}, 32'd0);
        chk("x0_err", {31'd0, err}, 32'd0);

        // Same-cycle set and clear on x9
        next_cycle();
        lu_issue = 1'b1; lu_issue_rd = 5'd9;
        next_cycle();
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
        push(5'd9, 32'h99);
        @(negedge clk);
        chk("x9_lu_ready", {31'd0, lu_ready}, 32'd1);
        next_cycle();
        lu_issue = 1'b0;
        lu_data = 32'hAA;
        push(5'd9, 32'hAA);
        @(negedge clk);
        chk("x9_busy_kept", {31'd0, busy[9]}, 32'd1);
        chk("x9_err", {31'd0, err}, 32'd0);
        next_cycle();
        lu_valid = 1'b0;
        @(negedge clk);
        chk("x9_busy_cleared", {31'd0, busy[9]}, 32'd0);
        chk("x9_err_after", {31'd0, err}, 32'd0);

        // Contract violation during the bubble
        next_cycle();
        lu_issue = 1'b1; lu_issue_rd = 5'd11;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            lu_issue = 1'b0;
            RegWriteW = 1'b1; RD_W = 5'd4; ResultW = 32'h4000_0000 + 32'(i);
            lu_valid = 1'b1; lu_rd = 5'd11; lu_data = 32'hBB;
            push(5'd4, 32'h4000_0000 + 32'(i));
            @(negedge clk);
            chk("v_wait_lu_ready", {31'd0, lu_ready}, 32'd0);
        end
        next_cycle();
        ResultW = 32'h4000_0005;
        push(5'd4, 32'h4000_0005);
        @(negedge clk);
        chk("v_stall", {31'd0, stall_req}, 32'd1);
        chk("v_lu_ready", {31'd0, lu_ready}, 32'd0);
        chk("v_err_not_yet", {31'd0, err}, 32'd0);
        next_cycle();
        RegWriteW = 1'b0; lu_valid = 1'b0;
        @(negedge clk);
        chk("v_err_set", {31'd0, err}, 32'd1);
        chk("v_stall_clear", {31'd0, stall_req}, 32'd0);
        chk("v_busy11", {31'd0, busy[11]}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("v_err_held", {31'd0, err}, 32'd1);

        // Fresh wait, then reset asserted during the bubble
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            RegWriteW = 1'b1; RD_W = 5'd4; ResultW = 32'h4100_0000 + 32'(i);
            lu_valid = 1'b1; lu_rd = 5'd11; lu_data = 32'hBB;
            push(5'd4, 32'h4100_0000 + 32'(i));
            @(negedge clk);
            chk("r_wait_stall", {31'd0, stall_req}, 32'd0);
        end
        next_cycle();
        RegWriteW = 1'b0;
        @(negedge clk);
        chk("r_stall_before_rst", {31'd0, stall_req}, 32'd1);
        chk("r_err_before_rst", {31'd0, err}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("r_stall_async", {31'd0, stall_req}, 32'd0);
        chk("r_err_async", {31'd0, err}, 32'd0);
        chk("r_busy_async", busy, 32'd0);
        chk("r_rf_we_async", {31'd0, rf_we}, 32'd0);
        chk("r_lu_ready_in_rst", {31'd0, lu_ready}, 32'd1);

        // Wait counter restarts from zero after reset release
        next_cycle();
        rst = 1'b1;
        lu_issue = 1'b1; lu_issue_rd = 5'd11;
        lu_data = 32'hCC;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin
                next_cycle();
                lu_issue = 1'b0;
            end
            RegWriteW = 1'b1; RD_W = 5'd4; ResultW = 32'h4200_0000 + 32'(i);
            push(5'd4, 32'h4200_0000 + 32'(i));
            @(negedge clk);
            chk("rr_lu_ready", {31'd0, lu_ready}, 32'd0);
            chk("rr_stall", {31'd0, stall_req}, 32'd0);
        end
        next_cycle();
        RegWriteW = 1'b0;
        push(5'd11, 32'hCC);
        @(negedge clk);
        chk("rr_bubble_stall", {31'd0, stall_req}, 32'd1);
        chk("rr_busy11", {31'd0, busy[11]}, 32'd1);
        next_cycle();
        lu_valid = 1'b0;
        @(negedge clk);
        chk("rr_busy_final", busy, 32'd0);
        chk("rr_err_final", {31'd0, err}, 32'd0);
        next_cycle();
        @(negedge clk);
        next_cycle();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
